// File: rtl/multi_flexcounter.sv
// multi_flexcounter: NUM_CH independent terminal-count timers with strobe/done.
// Define FLEXCOUNTER_PRESCALE_EN to add a shared prescaler that gates the count tick.
module multi_flexcounter #(
  parameter int NUM_CH = 4,
  parameter int COUNTSIZE = 10000,
  parameter int PRESCALE_WIDTH = 8,
  localparam int COUNTWIDTH = $clog2(COUNTSIZE)
) (
  input  logic clk,
  input  logic nRST,
  input  logic [NUM_CH-1:0] enableCounter,
  input  logic [NUM_CH-1:0] clearCounter,
  input  logic [NUM_CH-1:0] oneShot,
  input  logic [NUM_CH*COUNTWIDTH-1:0] maxCount,
`ifdef FLEXCOUNTER_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] prescaleDiv,
`endif
  output logic [NUM_CH*COUNTWIDTH-1:0] count,
  output logic [NUM_CH-1:0] strobe,
  output logic [NUM_CH-1:0] done,
  output logic anyStrobe
);

  logic tick;
  logic [COUNTWIDTH-1:0] max_a [NUM_CH];
  logic [COUNTWIDTH-1:0] cnt_q [NUM_CH];
  logic [COUNTWIDTH-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] strobe_d;
  logic [NUM_CH-1:0] done_d;

`ifdef FLEXCOUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] pre_q;

  // >= so a divisor lowered below the running value wraps at once
  assign tick = (pre_q >= prescaleDiv);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end
`else
  assign tick = (PRESCALE_WIDTH > 0);
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign max_a[g] = maxCount[g*COUNTWIDTH +: COUNTWIDTH];
    assign count[g*COUNTWIDTH +: COUNTWIDTH] = cnt_q[g];
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      done_d[i] = done[i];
      strobe_d[i] = 1'b0;
      if (clearCounter[i]) begin
        cnt_d[i] = '0;
        done_d[i] = 1'b0;
      end else if (!done[i] && enableCounter[i] && tick) begin
        if (cnt_q[i] >= max_a[i]) begin
          cnt_d[i] = '0;
          strobe_d[i] = 1'b1;
          done_d[i] = oneShot[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      strobe <= '0;
      done <= '0;
      anyStrobe <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      strobe <= strobe_d;
      done <= done_d;
      anyStrobe <= |strobe_d;
    end
  end

endmodule

// File: tb/tb_multi_flexcounter.sv
// tb_multi_flexcounter: directed checks of periodic, one-shot, clear,
// boundary, independence, async reset and tick-rate behaviour.
module tb_multi_flexcounter;
  localparam int NCH = 4;
  localparam int CW = 14;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic nRST;
  logic [NCH-1:0] enableCounter;
  logic [NCH-1:0] clearCounter;
  logic [NCH-1:0] oneShot;
  logic [NCH*CW-1:0] maxCount;
  logic [PW-1:0] prescaleDiv;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0] strobe;
  logic [NCH-1:0] done;
  logic anyStrobe;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_flexcounter #(
    .NUM_CH(NCH),
    .COUNTSIZE(10000),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .enableCounter(enableCounter),
    .clearCounter(clearCounter),
    .oneShot(oneShot),
    .maxCount(maxCount),
`ifdef FLEXCOUNTER_PRESCALE_EN
    .prescaleDiv(prescaleDiv),
`endif
    .count(count),
    .strobe(strobe),
    .done(done),
    .anyStrobe(anyStrobe)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setmax(input int i, input int v);
    maxCount[i*CW +: CW] = CW'(v);
  endtask

  function automatic logic [31:0] getc(input int i);
    return 32'(count[i*CW +: CW]);
  endfunction

  initial begin
    logic [NCH-1:0] exp_s;
    nRST = 1'b0;
    enableCounter = '0;
    clearCounter = '0;
    oneShot = '0;
    maxCount = '0;
    prescaleDiv = '0;

    // reset with toggling inputs
    for (int r = 0; r < 2; r++) begin
      enableCounter = NCH'($urandom);
      clearCounter = NCH'($urandom);
      oneShot = NCH'($urandom);
      for (int k = 0; k < NCH; k++) setmax(k, $urandom_range(0, 5));
      step();
    end
    chk("rst_count", 32'(count), 0);
    chk("rst_strobe", 32'(strobe), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_any", 32'(anyStrobe), 0);
    enableCounter = '0;
    clearCounter = '0;
    oneShot = '0;
    maxCount = '0;
    @(negedge clk);
    nRST = 1'b1;
    step();
    chk("rel_count", 32'(count), 0);
    chk("rel_strobe", 32'(strobe), 0);

    // periodic ch0, maxCount 3
    setmax(0, 3);
    enableCounter = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk($sformatf("per_cnt_e%0d", e), getc(0), e % 4);
      chk($sformatf("per_stb_e%0d", e), 32'(strobe), (e % 4 == 0) ? 1 : 0);
      chk($sformatf("per_any_e%0d", e), 32'(anyStrobe), (e % 4 == 0) ? 1 : 0);
    end
    enableCounter = '0;
    clearCounter = '1;
    step();
    clearCounter = '0;

    // one-shot ch1, maxCount 5
    oneShot = 4'b0010;
    setmax(1, 5);
    enableCounter = 4'b0010;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("os_cnt_e%0d", e), getc(1), (e == 6) ? 0 : e);
      chk($sformatf("os_stb_e%0d", e), 32'(strobe), (e == 6) ? 2 : 0);
      chk($sformatf("os_done_e%0d", e), 32'(done), (e == 6) ? 2 : 0);
    end
    for (int e = 0; e < 20; e++) begin
      step();
      chk("os_hold_cnt", getc(1), 0);
      chk("os_hold_stb", 32'(strobe), 0);
      chk("os_hold_done", 32'(done), 2);
    end
    clearCounter = 4'b0010;
    step();
    chk("os_clr_done", 32'(done), 0);
    chk("os_clr_cnt", getc(1), 0);
    chk("os_clr_stb", 32'(strobe), 0);
    clearCounter = '0;
    step();
    chk("os_resume_cnt", getc(1), 1);
    enableCounter = '0;
    clearCounter = '1;
    step();
    clearCounter = '0;
    oneShot = '0;

    // maxCount 0 periodic
    setmax(2, 0);
    enableCounter = 4'b0100;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("max0_stb", 32'(strobe), 4);
      chk("max0_cnt", getc(2), 0);
    end
    enableCounter = '0;

    // lower maxCount below running count
    setmax(3, 9);
    enableCounter = 4'b1000;
    repeat (7) step();
    chk("lower_pre_cnt", getc(3), 7);
    setmax(3, 2);
    step();
    chk("lower_stb", 32'(strobe), 8);
    chk("lower_cnt", getc(3), 0);
    step();
    chk("lower_next_cnt", getc(3), 1);
    chk("lower_next_stb", 32'(strobe), 0);
    // clear beats a would-be terminal count
    setmax(3, 1);
    clearCounter = 4'b1000;
    step();
    chk("clr_en_cnt", getc(3), 0);
    chk("clr_en_stb", 32'(strobe), 0);
    chk("clr_en_any", 32'(anyStrobe), 0);
    clearCounter = '1;
    enableCounter = '0;
    step();
    clearCounter = '0;

    // independent periods 2,3,4,5
    for (int k = 0; k < NCH; k++) setmax(k, k + 1);
    enableCounter = '1;
    for (int e = 1; e <= 12; e++) begin
      step();
      for (int k = 0; k < NCH; k++) begin
        exp_s[k] = (e % (k + 2) == 0);
        chk($sformatf("ind_cnt_ch%0d_e%0d", k, e), getc(k), e % (k + 2));
      end
      chk($sformatf("ind_stb_e%0d", e), 32'(strobe), 32'(exp_s));
      chk($sformatf("ind_any_e%0d", e), 32'(anyStrobe), 32'(|exp_s));
    end
    step();
    #2;
    nRST = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_strobe", 32'(strobe), 0);
    chk("async_done", 32'(done), 0);
    chk("async_any", 32'(anyStrobe), 0);

    // tick rate: prescaled or every cycle
    enableCounter = 4'b0001;
    maxCount = '0;
    setmax(0, 1);
    prescaleDiv = 8'd2;
    @(negedge clk);
    nRST = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
`ifdef FLEXCOUNTER_PRESCALE_EN
      chk($sformatf("tick_cnt_e%0d", e), getc(0), (e / 3) % 2);
      chk($sformatf("tick_stb_e%0d", e), 32'(strobe), (e % 6 == 0) ? 1 : 0);
`else
      chk($sformatf("tick_cnt_e%0d", e), getc(0), e % 2);
      chk($sformatf("tick_stb_e%0d", e), 32'(strobe), (e % 2 == 0) ? 1 : 0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
